reaction_game_hex2digit_monitor: RTL and testbench

- Watches the active-low seven-segment buses driven toward the HEX displays and recovers the shown digits. This is the decode direction of the digit-to-segment encoder.
- Filters glitches with a stability counter, then commits a decoded snapshot and pulses an update strobe.
- Sits on the display outputs as the score readback for the game controller, and doubles as the bench-side display checker.
- Counts snapshots containing illegal segment patterns.

---
 rtl/reaction_game_pkg.sv | 15 +
 rtl/reaction_game_hex2digit_monitor_if.sv | 24 ++
 rtl/reaction_game_hex2digit.sv | 23 ++
 rtl/reaction_game_hex2digit_monitor.sv | 105 ++++++++++
 tb/tb_reaction_game_hex2digit_monitor.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_game_pkg.sv
// Shared seven-segment definitions for the reaction game display path.
// The glyph table lives here so the encoder and the monitor cannot disagree.
package reaction_game_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low glyphs; entry i is the pattern shown for hex digit i.
    localparam seg7_t [15:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/reaction_game_hex2digit_monitor_if.sv
// Display-side bus of the digit monitor: raw segment inputs in, decoded snapshot out.
interface reaction_game_hex2digit_monitor_if #(
    parameter int NUM_DIGITS = 4,
    parameter int ERR_W      = 8
);
    logic [NUM_DIGITS*7-1:0] hex_in;
    logic                    sample_en;
    logic [NUM_DIGITS*4-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   blank_out;
    logic [NUM_DIGITS-1:0]   invalid_out;
    logic                    valid;
    logic                    update;
    logic [ERR_W-1:0]        err_count;

    modport master (
        output hex_in, sample_en,
        input  digits_out, blank_out, invalid_out, valid, update, err_count
    );

    modport slave (
        input  hex_in, sample_en,
        output digits_out, blank_out, invalid_out, valid, update, err_count
    );
endinterface

// File: rtl/reaction_game_hex2digit.sv
// Combinational decode of one active-low segment pattern back to its hex digit.
module reaction_game_hex2digit
    import reaction_game_pkg::*;
(
    input  seg7_t      seg_i,
    output logic [3:0] digit_o,
    output logic       blank_o,
    output logic       invalid_o
);

    always_comb begin
        digit_o   = 4'd0;
        blank_o   = (seg_i == SEG_BLANK);
        invalid_o = (seg_i != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_GLYPH[i]) begin
                digit_o   = 4'(i);
                invalid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reaction_game_hex2digit_monitor.sv
// Recovers displayed digits from the HEX segment buses, commits a snapshot once the
// whole bus has been stable long enough, and counts snapshots holding illegal glyphs.
module reaction_game_hex2digit_monitor
    import reaction_game_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    reaction_game_hex2digit_monitor_if.slave   bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS*7-1:0] s1_q, s1_d;
    logic [NUM_DIGITS*7-1:0] commit_q, commit_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS*4-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
    logic                    valid_q, valid_d;
    logic                    update_q, update_d;
    logic [ERR_W-1:0]        err_q, err_d;

    logic [NUM_DIGITS*4-1:0] dec_digits;
    logic [NUM_DIGITS-1:0]   dec_blank;
    logic [NUM_DIGITS-1:0]   dec_invalid;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        reaction_game_hex2digit u_dec (
            .seg_i     (s1_q[7*g +: 7]),
            .digit_o   (dec_digits[4*g +: 4]),
            .blank_o   (dec_blank[g]),
            .invalid_o (dec_invalid[g])
        );
    end

    always_comb begin
        s1_d      = s1_q;
        cnt_d     = cnt_q;
        commit_d  = commit_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        invalid_d = invalid_q;
        valid_d   = valid_q;
        update_d  = 1'b0;
        err_d     = err_q;
        if (bus.sample_en) begin
            s1_d = bus.hex_in;
            if (bus.hex_in == s1_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
            end else begin
                cnt_d = '0;
            end
            // A bus that settles back onto the committed pattern yields no new snapshot.
            if (cnt_q == CNT_MAX) begin
                valid_d = 1'b1;
                if (s1_q != commit_q) begin
                    commit_d  = s1_q;
                    digits_d  = dec_digits;
                    blank_d   = dec_blank;
                    invalid_d = dec_invalid;
                    update_d  = 1'b1;
                    if ((|dec_invalid) && (err_q != '1)) begin
                        err_d = err_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '1;
            cnt_q     <= '0;
            commit_q  <= '1;
            digits_q  <= '0;
            blank_q   <= '1;
            invalid_q <= '0;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
            err_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            cnt_q     <= cnt_d;
            commit_q  <= commit_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            invalid_q <= invalid_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            err_q     <= err_d;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.blank_out   = blank_q;
    assign bus.invalid_out = invalid_q;
    assign bus.valid       = valid_q;
    assign bus.update      = update_q;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_reaction_game_hex2digit_monitor.sv
// Bench for the HEX digit monitor: sliding-window reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reaction_game_hex2digit_monitor;

    localparam int ND = 4;
    localparam int ST = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reaction_game_hex2digit_monitor_if #(.NUM_DIGITS(ND), .ERR_W(EW)) bus ();

    reaction_game_hex2digit_monitor #(
        .NUM_DIGITS(ND), .STABLE_CYCLES(ST), .ERR_W(EW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Returns {invalid, blank, digit[3:0]} for one segment pattern.
    function automatic logic [5:0] ref_dec(input logic [6:0] s);
        if (s == 7'h7F) return 6'b010000;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == s) return {2'b00, i[3:0]};
        end
        return 6'b100000;
    endfunction

    function automatic logic [27:0] pack4(input logic [6:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    // Reference: keep the last ST+1 enabled samples (reset counts as one sample of all-off);
    // the bus is stable when all of them agree.
    logic [27:0] win [0:ST];
    int          win_n;
    logic [27:0] m_commit;
    logic [15:0] m_digits;
    logic [3:0]  m_blank, m_inv;
    logic        m_valid, m_upd;
    logic [7:0]  m_err;

    always @(posedge clk or negedge rst_n) begin : model
        logic       stable;
        logic [5:0] r;
        logic [15:0] nd;
        logic [3:0]  nb, ni;
        if (!rst_n) begin
            for (int i = 0; i <= ST; i++) win[i] <= '1;
            win_n    <= 1;
            m_commit <= '1;
            m_digits <= '0;
            m_blank  <= '1;
            m_inv    <= '0;
            m_valid  <= 1'b0;
            m_upd    <= 1'b0;
            m_err    <= '0;
        end else if (bus.sample_en) begin
            stable = (win_n == ST + 1);
            for (int i = 1; i <= ST; i++) if (win[i] != win[0]) stable = 1'b0;
            m_upd <= 1'b0;
            if (stable) begin
                m_valid <= 1'b1;
                if (win[0] != m_commit) begin
                    for (int d = 0; d < ND; d++) begin
                        r = ref_dec(win[0][7*d +: 7]);
                        nd[4*d +: 4] = r[3:0];
                        nb[d] = r[4];
                        ni[d] = r[5];
                    end
                    m_commit <= win[0];
                    m_digits <= nd;
                    m_blank  <= nb;
                    m_inv    <= ni;
                    m_upd    <= 1'b1;
                    if ((ni != 4'd0) && (m_err != 8'hFF)) m_err <= m_err + 8'd1;
                end
            end
            win[0] <= bus.hex_in;
            for (int i = 1; i <= ST; i++) win[i] <= win[i-1];
            win_n <= (win_n < ST + 1) ? win_n + 1 : win_n;
        end else begin
            m_upd <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic cmp_en = 1'b0;
    int   upd_cnt = 0;
    int   last_upd_cyc = -1;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("digits_out", 32'(bus.digits_out), 32'(m_digits));
            chk("blank_out", 32'(bus.blank_out), 32'(m_blank));
            chk("invalid_out", 32'(bus.invalid_out), 32'(m_inv));
            chk("valid", 32'(bus.valid), 32'(m_valid));
            chk("update", 32'(bus.update), 32'(m_upd));
            chk("err_count", 32'(bus.err_count), 32'(m_err));
            if (bus.update) begin
                upd_cnt++;
                last_upd_cyc = cyc;
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_digits"}, 32'(bus.digits_out), 32'h0);
        chk({tag, "_blank"}, 32'(bus.blank_out), 32'hF);
        chk({tag, "_invalid"}, 32'(bus.invalid_out), 32'h0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'h0);
        chk({tag, "_update"}, 32'(bus.update), 32'h0);
        chk({tag, "_err"}, 32'(bus.err_count), 32'h0);
    endtask

    int base, c0;

    initial begin
        rst_n         = 1'b0;
        bus.hex_in    = '1;
        bus.sample_en = 1'b1;
        step(2);
        chk_reset_vals("rst0");
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Idle blank display never pulses update.
        base = upd_cnt;
        step(20);
        chk("idle_updates", 32'(upd_cnt - base), 32'd0);
        chk("idle_valid", 32'(bus.valid), 32'd1);
        chk("idle_blank", 32'(bus.blank_out), 32'hF);
        chk("idle_err", 32'(bus.err_count), 32'd0);

        // Single digit 2 on digit0.
        base = upd_cnt; c0 = cyc;
        bus.hex_in = pack4(7'h7F, 7'h7F, 7'h7F, 7'h24);
        step(10);
        chk("d2_updates", 32'(upd_cnt - base), 32'd1);
        chk("d2_latency", 32'(last_upd_cyc - c0), 32'd6);
        chk("d2_digit0", 32'(bus.digits_out[3:0]), 32'd2);
        chk("d2_blank", 32'(bus.blank_out), 32'b1110);

        // Toggling faster than the stability window never commits.
        base = upd_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.hex_in = pack4(7'h7F, 7'h7F, 7'h7F, (i % 2 == 0) ? 7'h30 : 7'h24);
            step(2);
        end
        chk("tog_updates", 32'(upd_cnt - base), 32'd0);
        bus.hex_in = pack4(7'h7F, 7'h7F, 7'h7F, 7'h30);
        step(10);
        chk("tog_hold_updates", 32'(upd_cnt - base), 32'd1);
        chk("tog_digit0", 32'(bus.digits_out[3:0]), 32'd3);

        // Illegal pattern on digit1, then saturate the error counter.
        bus.hex_in = pack4(7'h7F, 7'h7F, 7'h55, 7'h7F);
        step(10);
        chk("ill_invalid", 32'(bus.invalid_out), 32'b0010);
        chk("ill_digit1", 32'(bus.digits_out[7:4]), 32'd0);
        chk("ill_err", 32'(bus.err_count), 32'd1);
        for (int i = 0; i < 300; i++) begin
            bus.hex_in = pack4(7'h7F, 7'h7F, (i % 2 == 0) ? 7'h56 : 7'h55, 7'h7F);
            step(7);
        end
        chk("sat_err", 32'(bus.err_count), 32'hFF);

        // Frozen while sample_en is low, then commit once re-enabled.
        base = upd_cnt;
        bus.hex_in    = pack4(7'h7F, 7'h7F, 7'h7F, 7'h19);
        bus.sample_en = 1'b0;
        step(10);
        chk("frz_updates", 32'(upd_cnt - base), 32'd0);
        c0 = cyc;
        bus.sample_en = 1'b1;
        step(10);
        chk("frz_updates2", 32'(upd_cnt - base), 32'd1);
        chk("frz_latency", 32'(last_upd_cyc - c0), 32'd6);
        chk("frz_digit0", 32'(bus.digits_out[3:0]), 32'd4);

        // Freeze right as update is high: it must drop and not re-fire.
        base = upd_cnt;
        bus.hex_in = pack4(7'h7F, 7'h7F, 7'h7F, 7'h12);
        step(6);
        chk("frz2_upd_high", 32'(bus.update), 32'd1);
        bus.sample_en = 1'b0;
        step(3);
        chk("frz2_upd_low", 32'(bus.update), 32'd0);
        chk("frz2_updates", 32'(upd_cnt - base), 32'd1);
        chk("frz2_digit0", 32'(bus.digits_out[3:0]), 32'd5);
        bus.sample_en = 1'b1;

        // Reset mid-count.
        bus.hex_in = pack4(7'h7F, 7'h7F, 7'h7F, 7'h78);
        step(2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        step(1);
        base = upd_cnt;
        rst_n = 1'b1;
        step(10);
        chk("rst_mid_updates", 32'(upd_cnt - base), 32'd1);
        chk("rst_mid_digit0", 32'(bus.digits_out[3:0]), 32'd7);

        // Reset after a commit.
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_post");
        step(1);
        base = upd_cnt;
        rst_n = 1'b1;
        step(10);
        chk("rst_post_updates", 32'(upd_cnt - base), 32'd1);
        chk("rst_post_digit0", 32'(bus.digits_out[3:0]), 32'd7);
        chk("rst_post_err", 32'(bus.err_count), 32'd0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
